// File: rtl/stopwatch_datapath_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_datapath_pkg
// Definitions shared by the stopwatch timekeeping stage and the FND display
// controller downstream of it:
//   - run/stop/clear FSM state encoding
//   - widths of the hour/min/sec/csec fields
//   - bit offsets of each field inside the packed 24-bit time word
// -----------------------------------------------------------------------------
package stopwatch_datapath_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Field widths
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned CSEC_W = 7;

    // Packed time word layout: {hour, min, sec, csec}
    localparam int unsigned TIME_W   = 24;
    localparam int unsigned HOUR_LSB = 19;
    localparam int unsigned MIN_LSB  = 13;
    localparam int unsigned SEC_LSB  = 7;
    localparam int unsigned CSEC_LSB = 0;

endpackage

// File: rtl/stopwatch_datapath_time_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_datapath_time_counter
// Parameterised mod-N counter used as one stage of the time cascade.
// Ports:
//   clk    in      system clock
//   reset  in      asynchronous, active-high reset
//   inc    in      advance by one (wraps N-1 -> 0)
//   clr    in      synchronous zero, takes priority over inc
//   value  out [W] current count, always in 0..N-1
//   carry  out     high when inc arrives while value == N-1
// -----------------------------------------------------------------------------
module stopwatch_datapath_time_counter #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    logic at_max;

    assign at_max = (value == W'(N - 1));
    assign carry  = inc && at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_datapath.sv
// -----------------------------------------------------------------------------
// stopwatch_datapath
// Stopwatch timekeeping stage: divides the system clock to a 1/100 s tick and
// runs a csec -> sec -> min -> hour counter cascade under a run/stop/clear FSM.
// Ports:
//   clk          in       system clock (100 MHz)
//   reset        in       asynchronous, active-high reset
//   i_run_stop   in       one-cycle pulse, toggles run/stop
//   i_clear      in       one-cycle pulse, zeroes time (only while stopped)
//   o_time_data  out [24] {hour[4:0], min[5:0], sec[5:0], csec[6:0]}
//   o_running    out      high while running
//   o_tick       out      one-cycle pulse, aligned with each new time value
// -----------------------------------------------------------------------------
module stopwatch_datapath
    import stopwatch_datapath_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned CSEC_MAX = 100,
    parameter int unsigned SEC_MAX  = 60,
    parameter int unsigned MIN_MAX  = 60,
    parameter int unsigned HOUR_MAX = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run_stop,
    input  logic              i_clear,
    output logic [TIME_W-1:0] o_time_data,
    output logic              o_running,
    output logic              o_tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             clr_cnt;

    logic [CSEC_W-1:0] csec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic              csec_carry;
    logic              sec_carry;
    logic              min_carry;
    logic              unused_day_carry;

    // FSM: clear beats run_stop in STOP, run_stop beats clear in RUN
    always_comb begin
        state_next = state;
        case (state)
            ST_STOP: begin
                if (i_clear) begin
                    state_next = ST_CLEAR;
                end else if (i_run_stop) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_run_stop) begin
                    state_next = ST_STOP;
                end
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    assign tick    = (state == ST_RUN) && (div == DIV_W'(TICK_DIV - 1));
    assign clr_cnt = (state == ST_CLEAR);

    // Divider holds its phase while stopped so a resume finishes the partial period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_STOP;
            div    <= '0;
            o_tick <= 1'b0;
        end else begin
            state  <= state_next;
            o_tick <= tick;
            if (clr_cnt) begin
                div <= '0;
            end else if (state == ST_RUN) begin
                div <= tick ? '0 : div + 1'b1;
            end
        end
    end

    assign o_running = (state == ST_RUN);

    stopwatch_datapath_time_counter #(.N(CSEC_MAX), .W(CSEC_W)) u_csec (
        .clk   (clk),
        .reset (reset),
        .inc   (tick),
        .clr   (clr_cnt),
        .value (csec),
        .carry (csec_carry)
    );

    stopwatch_datapath_time_counter #(.N(SEC_MAX), .W(SEC_W)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (csec_carry),
        .clr   (clr_cnt),
        .value (sec),
        .carry (sec_carry)
    );

    stopwatch_datapath_time_counter #(.N(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_carry),
        .clr   (clr_cnt),
        .value (min),
        .carry (min_carry)
    );

    // Day wrap has no further effect
    stopwatch_datapath_time_counter #(.N(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (min_carry),
        .clr   (clr_cnt),
        .value (hour),
        .carry (unused_day_carry)
    );

    always_comb begin
        o_time_data                          = '0;
        o_time_data[HOUR_LSB +: HOUR_W]      = hour;
        o_time_data[MIN_LSB  +: MIN_W]       = min;
        o_time_data[SEC_LSB  +: SEC_W]       = sec;
        o_time_data[CSEC_LSB +: CSEC_W]      = csec;
    end

endmodule

// File: tb/tb_stopwatch_datapath.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_datapath
// Two instances share stimulus: one with default moduli and TICK_DIV = 4, one
// with tiny moduli and TICK_DIV = 1 so the full day wrap is reachable quickly.
// Expected time is derived from an elapsed-tick count split into fields.
// -----------------------------------------------------------------------------
module tb_stopwatch_datapath;

    localparam int M_STOP  = 0;
    localparam int M_RUN   = 1;
    localparam int M_CLEAR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_stop;
    logic        clear;
    logic [23:0] time0, time1;
    logic        running0, running1;
    logic        tick0, tick1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int mode;
    int phase [2];
    int total [2];
    bit exp_tick [2];
    int div_v [2] = '{4, 1};
    int cmod  [2] = '{100, 4};
    int smod  [2] = '{60, 3};
    int mmod  [2] = '{60, 3};
    int hmod  [2] = '{24, 2};

    always #5 clk = ~clk;

    stopwatch_datapath #(.TICK_DIV(4)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .i_run_stop  (run_stop),
        .i_clear     (clear),
        .o_time_data (time0),
        .o_running   (running0),
        .o_tick      (tick0)
    );

    stopwatch_datapath #(
        .TICK_DIV (1),
        .CSEC_MAX (4),
        .SEC_MAX  (3),
        .MIN_MAX  (3),
        .HOUR_MAX (2)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .i_run_stop  (run_stop),
        .i_clear     (clear),
        .o_time_data (time1),
        .o_running   (running1),
        .o_tick      (tick1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack_time(input int k);
        int t, cs, sc, mn, hr;
        t  = total[k] % (cmod[k] * smod[k] * mmod[k] * hmod[k]);
        cs = t % cmod[k];
        t  = t / cmod[k];
        sc = t % smod[k];
        t  = t / smod[k];
        mn = t % mmod[k];
        hr = t / mmod[k];
        return 24'((hr << 19) | (mn << 13) | (sc << 7) | cs);
    endfunction

    task automatic model_reset();
        mode = M_STOP;
        for (int k = 0; k < 2; k++) begin
            phase[k]    = 0;
            total[k]    = 0;
            exp_tick[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit rs_v, input bit cl_v);
        for (int k = 0; k < 2; k++) begin
            exp_tick[k] = (mode == M_RUN) && (phase[k] == div_v[k] - 1);
            if (mode == M_CLEAR) begin
                total[k] = 0;
                phase[k] = 0;
            end else if (mode == M_RUN) begin
                if (exp_tick[k]) begin
                    phase[k] = 0;
                    total[k] = total[k] + 1;
                end else begin
                    phase[k] = phase[k] + 1;
                end
            end
        end
        case (mode)
            M_STOP:  mode = cl_v ? M_CLEAR : (rs_v ? M_RUN : M_STOP);
            M_RUN:   mode = rs_v ? M_STOP : M_RUN;
            default: mode = M_STOP;
        endcase
    endtask

    task automatic check_outputs();
        check_eq("time0", 32'(time0), 32'(pack_time(0)));
        check_eq("running0", 32'(running0), 32'(mode == M_RUN));
        check_eq("tick0", 32'(tick0), 32'(exp_tick[0]));
        check_eq("time1", 32'(time1), 32'(pack_time(1)));
        check_eq("running1", 32'(running1), 32'(mode == M_RUN));
        check_eq("tick1", 32'(tick1), 32'(exp_tick[1]));
    endtask

    task automatic cycle(input bit rs_v, input bit cl_v);
        @(negedge clk);
        run_stop = rs_v;
        clear    = cl_v;
        @(posedge clk);
        model_edge(rs_v, cl_v);
        #1;
        check_outputs();
    endtask

    task automatic stop_and_clear();
        if (mode == M_RUN) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_eq("cleared_time0", 32'(time0), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        run_stop = 1'b0;
        clear    = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        repeat (50) cycle(1'b0, 1'b0);

        // 400 cycles at TICK_DIV = 4 -> 1.00 s
        cycle(1'b1, 1'b0);
        repeat (400) cycle(1'b0, 1'b0);
        check_eq("one_second", 32'(time0), 32'h000080);
        check_eq("running_after_400", 32'(running0), 32'h1);

        // Pause/resume keeps the partial divider period
        stop_and_clear();
        cycle(1'b1, 1'b0);
        repeat (40) cycle(1'b0, 1'b0);
        check_eq("csec10", 32'(time0), 32'd10);
        repeat (2) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0);
            check_eq("held_csec10", 32'(time0), 32'd10);
        end
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check_eq("resume_csec11", 32'(time0), 32'd11);
        repeat (4) cycle(1'b0, 1'b0);
        check_eq("resume_csec12", 32'(time0), 32'd12);

        // Clear ignored while running; clear beats run_stop while stopped
        cycle(1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        check_eq("clear_wins_time", 32'(time0), 32'h0);
        check_eq("clear_wins_running", 32'(running0), 32'h0);

        // Randomised pulses
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 49));
            cycle(r == 0 || r == 3, r == 1 || r == 2 || r == 3);
        end

        // Cascade and day wrap on the small-moduli instance
        stop_and_clear();
        cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b0);
        check_eq("w_sec_boundary", 32'(time1), 32'h000080);
        repeat (8) cycle(1'b0, 1'b0);
        check_eq("w_min_boundary", 32'(time1), 32'h002000);
        repeat (24) cycle(1'b0, 1'b0);
        check_eq("w_hour_boundary", 32'(time1), 32'h080000);
        repeat (36) cycle(1'b0, 1'b0);
        check_eq("w_day_wrap", 32'(time1), 32'h000000);

        // One full minute on the default-moduli instance
        stop_and_clear();
        cycle(1'b1, 1'b0);
        repeat (24000) cycle(1'b0, 1'b0);
        check_eq("one_minute", 32'(time0), 32'h002000);

        // Asynchronous reset mid-run at csec = 37
        stop_and_clear();
        cycle(1'b1, 1'b0);
        repeat (148) cycle(1'b0, 1'b0);
        check_eq("csec37", 32'(time0), 32'd37);
        @(negedge clk);
        run_stop = 1'b0;
        clear    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) cycle(1'b0, 1'b0);
        check_eq("post_reset_idle", 32'(time0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
